piso_bit_serializer: RTL and testbench
======================================

Name: piso_bit_serializer

Overview:
- Parallel-in serial-out stage that feeds serial bit-stream consumers such as the Mealy sequence detectors.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Emits the word one bit per enabled clock on x_out, qualified by x_valid.
- Pulses done when the last bit has been consumed.

Parameters:
- WIDTH, 8, word length in bits; must be >= 2.
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to serialize; sampled only on an accepted load.
- load_valid  input  1  upstream has a word on data_in.
- load_ready  output  1  serializer can accept a word.
- shift_en  input  1  downstream consumes the current bit at this edge; tie to 1 for free-running.
- x_out  output  1  current serial bit; stable for the whole cycle.
- x_valid  output  1  x_out holds a valid bit.
- busy  output  1  word in flight (equals ~load_ready).
- done  output  1  one-cycle pulse after the final bit is consumed.

Behaviour:
- Reset (reset=0, asynchronous and immediate):
  - state=IDLE, shift register=0, bit counter=0.
  - x_out=0, x_valid=0, load_ready=1, busy=0, done=0.
- States: IDLE, SHIFT, plus PARITY only with the optional feature.
- IDLE:
  - load_ready=1, x_valid=0, x_out=0.
  - shift_en is ignored.
  - Edge with load_valid=1: capture data_in, counter=0, go to SHIFT. This edge is the accept edge.
- SHIFT:
  - load_ready=0, x_valid=1.
  - x_out = sreg[WIDTH-1] when MSB_FIRST=1, else sreg[0]. It is a register output, not a combinational path from data_in.
  - Edge with shift_en=1 and counter < WIDTH-1: shift one position toward the output end, zero-fill the vacated bit, counter+1.
  - Edge with shift_en=1 and counter == WIDTH-1: go to IDLE (or PARITY when the feature is enabled). done=1 for the following cycle only.
  - Edge with shift_en=0: sreg, counter and state all hold; x_out stays unchanged.
- Latency:
  - First bit is valid the cycle after the accept edge.
  - With shift_en held at 1, the word occupies exactly WIDTH cycles.
  - load_ready returns to 1 the cycle after the last bit is consumed, coincident with done=1.
  - No back-to-back overlap: minimum one IDLE cycle between words.
- load_valid while busy is ignored. data_in is not sampled and the in-flight word is unaffected.
- done is registered and is 0 in every cycle other than the single pulse.
- Counter width is clog2(WIDTH); the counter never wraps past WIDTH-1.
- Reset mid-word: partial word discarded, outputs take reset values at once, and the next load restarts from bit 0.
- Downstream detectors sample x_out on the same clk edge. A Mealy consumer sees each bit for one full cycle when shift_en=1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit is consumed, enter PARITY.
  - x_out = even parity (XOR-reduce of the word captured at load), x_valid=1.
  - On shift_en=1, go to IDLE and pulse done.
  - The word takes WIDTH+1 enabled cycles.
- Undefined: PARITY state and its logic are absent; done follows the last data bit.

Test Plan:
- Reset: hold reset=0 for 2 cycles with load_valid=1 -> x_valid=0, x_out=0, load_ready=1, busy=0, done=0 throughout.
- WIDTH=8, MSB_FIRST=1, load 8'b11011010, shift_en=1 -> x_out=1,1,0,1,1,0,1,0 on 8 consecutive cycles, then done=1 for one cycle and load_ready=1. With a downstream 1101 Mealy detector connected, y=1 during the 4th and 7th bit cycles only.
- MSB_FIRST=0, load 8'hA5 -> x_out=1,0,1,0,0,1,0,1; done pulses once after the 8th bit.
- Stall: load 8'hF0 (MSB first), drop shift_en for 3 cycles after the 2nd bit -> x_out holds 1 and x_valid stays 1. Sequence resumes 1,1,0,0,0,0 and done pulses after 8 enabled edges.
- Busy load: during a word, present load_valid=1 with data_in=8'h00 -> load_ready=0, original bits emitted unchanged, no extra word emitted afterward.
- Reset mid-word: assert reset after 3 bits of 8'hFF -> x_valid falls immediately, load_ready=1. A new load of 8'h81 emits 1,0,0,0,0,0,0,1 from bit 0.
- With PISO_PARITY_EN: load 8'h07 -> 8 data bits followed by parity bit 1, done one cycle later.

Source files
------------

// File: rtl/piso_bit_serializer.sv
// rtl/piso_bit_serializer.sv - parallel-in serial-out bit serializer with load handshake (optional parity bit: PISO_PARITY_EN)
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // State, shift register, bit counter and done pulse; async active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and output decode; outputs depend only on registered state
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
`ifdef PISO_PARITY_EN
    par_d      = par_q;
`endif
    load_ready = 1'b0;
    x_valid    = 1'b0;
    x_out      = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          sreg_d  = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef PISO_PARITY_EN
          par_d   = ^data_in;
`endif
        end
      end
      SHIFT: begin
        x_valid = 1'b1;
        x_out   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        if (shift_en) begin
          if (cnt_q == LAST) begin
            // Clear the datapath so a stale bit never lingers into IDLE
            sreg_d  = '0;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg_q[WIDTH-1:1]};
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        x_valid = 1'b1;
        x_out   = par_q;
        if (shift_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = ~load_ready;
  assign done = done_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// tb/tb_piso_bit_serializer.sv - self-checking bench for piso_bit_serializer (MSB-first and LSB-first instances)
module tb_piso_bit_serializer;

`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       shift_en;

  logic lr_m, xo_m, xv_m, bz_m, dn_m;
  logic lr_l, xo_l, xv_l, bz_l, dn_l;

  int checks = 0;
  int errors = 0;

  // Expected bit streams still to be emitted by each instance
  logic qm[$];
  logic ql[$];
  logic dm_exp = 1'b0;
  logic dl_exp = 1'b0;

  // Observed consumed bits (first bit ends up most significant) and done pulses
  logic [15:0] cap_m, cap_l;
  int nm, nl, dcm, dcl;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr_m), .shift_en(shift_en), .x_out(xo_m), .x_valid(xv_m),
    .busy(bz_m), .done(dn_m)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr_l), .shift_en(shift_en), .x_out(xo_l), .x_valid(xv_l),
    .busy(bz_l), .done(dn_l)
  );

  task automatic chk(input string nm_s, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm_s, act, exp);
    end
  endtask

  // Compare DUT outputs with the stream model, then advance the model for the coming edge
  always @(negedge clk) begin
    if (!reset) begin
      qm.delete();
      ql.delete();
      dm_exp = 1'b0;
      dl_exp = 1'b0;
    end
    chk("m_x_valid",    xv_m, qm.size() != 0);
    chk("m_x_out",      xo_m, (qm.size() != 0) ? qm[0] : 1'b0);
    chk("m_load_ready", lr_m, qm.size() == 0);
    chk("m_busy",       bz_m, qm.size() != 0);
    chk("m_done",       dn_m, dm_exp);
    chk("l_x_valid",    xv_l, ql.size() != 0);
    chk("l_x_out",      xo_l, (ql.size() != 0) ? ql[0] : 1'b0);
    chk("l_load_ready", lr_l, ql.size() == 0);
    chk("l_busy",       bz_l, ql.size() != 0);
    chk("l_done",       dn_l, dl_exp);
    if (xv_m && shift_en) begin cap_m = {cap_m[14:0], xo_m}; nm++; end
    if (xv_l && shift_en) begin cap_l = {cap_l[14:0], xo_l}; nl++; end
    if (dn_m) dcm++;
    if (dn_l) dcl++;
    if (reset) begin
      dm_exp = 1'b0;
      dl_exp = 1'b0;
      if (qm.size() == 0) begin
        if (load_valid) begin
          for (int i = 0; i < 8; i++) qm.push_back(data_in[7-i]);
`ifdef PISO_PARITY_EN
          qm.push_back(^data_in);
`endif
        end
      end else if (shift_en) begin
        void'(qm.pop_front());
        if (qm.size() == 0) dm_exp = 1'b1;
      end
      if (ql.size() == 0) begin
        if (load_valid) begin
          for (int i = 0; i < 8; i++) ql.push_back(data_in[i]);
`ifdef PISO_PARITY_EN
          ql.push_back(^data_in);
`endif
        end
      end else if (shift_en) begin
        void'(ql.pop_front());
        if (ql.size() == 0) dl_exp = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_caps();
    cap_m = '0; cap_l = '0; nm = 0; nl = 0; dcm = 0; dcl = 0;
  endtask

  task automatic send(input logic [7:0] w);
    data_in    = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic run_word(input logic [7:0] w);
    clear_caps();
    shift_en = 1'b1;
    send(w);
    repeat (NB) step();
    repeat (2) step();
  endtask

  // Hand-computed literal stream for one instance
  task automatic chk_stream(input string nm_s, input logic [15:0] cap, input int n, input int dc,
                            input logic [7:0] exp_bits, input logic exp_par);
    chk({nm_s, "_len"}, n, NB);
    chk({nm_s, "_done_pulses"}, dc, 1);
`ifdef PISO_PARITY_EN
    chk({nm_s, "_bits"}, cap[8:1], exp_bits);
    chk({nm_s, "_parity"}, cap[0], exp_par);
`else
    chk({nm_s, "_bits"}, cap[7:0], exp_bits);
    chk({nm_s, "_parity_unused"}, {31'd0, exp_par} & 32'd0, 32'd0 & {31'd0, cap[0]});
`endif
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b1;
    data_in    = 8'hFF;
    shift_en   = 1'b1;
    clear_caps();
    repeat (2) step();
    reset      = 1'b1;
    load_valid = 1'b0;
    step();

    run_word(8'b11011010);
    chk_stream("msb_DA", cap_m, nm, dcm, 8'b11011010, 1'b1);

    run_word(8'hA5);
    chk_stream("lsb_A5", cap_l, nl, dcl, 8'b10100101, 1'b0);

    // Stall after the second bit for three cycles
    clear_caps();
    shift_en = 1'b1;
    send(8'hF0);
    repeat (2) step();
    shift_en = 1'b0;
    repeat (3) step();
    shift_en = 1'b1;
    repeat (NB - 2) step();
    repeat (2) step();
    chk_stream("msb_stall_F0", cap_m, nm, dcm, 8'b11110000, 1'b0);

    // Load attempt while busy must be ignored
    clear_caps();
    shift_en = 1'b1;
    send(8'h3C);
    repeat (2) step();
    data_in    = 8'h00;
    load_valid = 1'b1;
    repeat (3) step();
    load_valid = 1'b0;
    repeat (NB - 5) step();
    repeat (3) step();
    chk_stream("msb_busy_3C", cap_m, nm, dcm, 8'b00111100, 1'b0);

    // Reset after three bits of a word
    clear_caps();
    shift_en = 1'b1;
    send(8'hFF);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_mid_m_x_valid", xv_m, 1'b0);
    chk("rst_mid_m_x_out", xo_m, 1'b0);
    chk("rst_mid_m_load_ready", lr_m, 1'b1);
    chk("rst_mid_l_busy", bz_l, 1'b0);
    step();
    reset = 1'b1;
    step();
    run_word(8'h81);
    chk_stream("msb_81", cap_m, nm, dcm, 8'b10000001, 1'b0);
    chk_stream("lsb_81", cap_l, nl, dcl, 8'b10000001, 1'b0);

    run_word(8'h07);
    chk_stream("msb_07", cap_m, nm, dcm, 8'b00000111, 1'b1);
    chk_stream("lsb_07", cap_l, nl, dcl, 8'b11100000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
